fsm_driver: RTL and testbench

Sequencer that sits on the initiator side of the `fsm` controller's start/done handshake. It queues task requests, issues a one-cycle `start` to the controller, and confirms that the controller reports busy (`state == 8'd1`). It then models a task of fixed latency, pulses `done`, and confirms the controller returns to idle (`state == 8'd0`). It is used as the traffic source when the controller is integrated in hardware and as a self-checking driver in CI.

---
 rtl/fsm_driver.sv | 103 ++++++++++
 tb/tb_fsm_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_driver.sv
// Initiator-side sequencer for the fsm start/done handshake: queues requests,
// issues start, models a fixed-latency task, issues done and tracks completions.
module fsm_driver #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  state,
  output logic        start,
  output logic        done,
  output logic [7:0]  pending,
  output logic [15:0] completed,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WORK,
    FINISH,
    WAIT_IDLE,
    ERROR
  } seq_state_t;

  localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  seq_state_t cur, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       complete;
  logic       inc;

  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt;
    complete = 1'b0;
    case (cur)
      IDLE:      if (pending != 8'd0) nxt = ISSUE;
      ISSUE:     nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (state == 8'd1)       nxt = WORK;
        else if (cnt == TO_LAST) nxt = ERROR;
        else                     cnt_nxt = cnt + 8'd1;
      end
      WORK: begin
        if (cnt == LAT_LAST) nxt = FINISH;
        else                 cnt_nxt = cnt + 8'd1;
      end
      FINISH:    nxt = WAIT_IDLE;
      WAIT_IDLE: begin
        if (state == 8'd0) begin
          nxt      = IDLE;
          complete = 1'b1;
        end else if (cnt == TO_LAST) begin
          nxt = ERROR;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ERROR:     nxt = ERROR;
      default:   nxt = ERROR;
    endcase
    // An illegal controller state overrides every in-flight decision, including a completion.
    if (cur != IDLE && cur != ERROR && state > 8'd1) begin
      nxt      = ERROR;
      complete = 1'b0;
    end
    if (nxt != cur) cnt_nxt = '0;
  end

  assign inc = req && (cur != ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= IDLE;
      cnt       <= '0;
      start     <= 1'b0;
      done      <= 1'b0;
      pending   <= '0;
      completed <= '0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      // Strobes are registered from the next state so they align exactly with ISSUE/FINISH.
      start <= (nxt == ISSUE);
      done  <= (nxt == FINISH);
      case ({inc, complete})
        2'b10:   if (pending != 8'hFF) pending <= pending + 8'd1;
        2'b01:   pending <= pending - 8'd1;
        default: pending <= pending;
      endcase
      if (complete) completed <= completed + 16'd1;
    end
  end

  assign busy  = (cur != IDLE);
  assign error = (cur == ERROR);

endmodule

// File: tb/tb_fsm_driver.sv
// Directed self-checking bench for fsm_driver with a behavioural fsm controller
// model plus a second instance with a long timeout for pending saturation.
module tb_fsm_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [7:0]  dut_state;
  logic        start, done, busy, error;
  logic [7:0]  pending;
  logic [15:0] completed;

  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_val = 8'd0;
  logic [7:0]  ctrl;

  logic        sat_req = 1'b0;
  logic [7:0]  sat_state = 8'd1;
  logic        sat_start, sat_done, sat_busy, sat_error;
  logic [7:0]  sat_pending;
  logic [15:0] sat_completed;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_q[$];

  always #5 clock = ~clock;

  fsm_driver #(.LATENCY(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .req(req), .state(dut_state),
    .start(start), .done(done), .pending(pending), .completed(completed),
    .busy(busy), .error(error)
  );

  fsm_driver #(.LATENCY(4), .TIMEOUT(255)) dut_sat (
    .clock(clock), .reset(reset), .req(sat_req), .state(sat_state),
    .start(sat_start), .done(sat_done), .pending(sat_pending), .completed(sat_completed),
    .busy(sat_busy), .error(sat_error)
  );

  // Controller model: registers start -> busy, done -> idle.
  always @(posedge clock) begin
    if (reset)      ctrl <= 8'd0;
    else if (start) ctrl <= 8'd1;
    else if (done)  ctrl <= 8'd0;
  end
  assign dut_state = ovr_en ? ovr_val : ctrl;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (start === 1'b1) start_q.push_back(cyc);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++;
    if ({start, done, busy, error} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {start, done, busy, error});
    end
    tests++;
    if (pending !== 8'd0) begin
      fails++; $display("FAIL reset_pending: got %0d expected 0", pending);
    end
    tests++;
    if (completed !== 16'd0) begin
      fails++; $display("FAIL reset_completed: got %0d expected 0", completed);
    end
  endtask

  task automatic test_single();
    int k;
    req = 1'b1;
    tick();
    req = 1'b0;
    tests++;
    if ({pending, start} !== {8'd1, 1'b0}) begin
      fails++; $display("FAIL single_queued: got %h expected %h", {pending, start}, {8'd1, 1'b0});
    end
    tick();
    tests++;
    if ({start, busy, dut_state} !== {1'b1, 1'b1, 8'd0}) begin
      fails++; $display("FAIL single_issue: got %h expected %h", {start, busy, dut_state}, {1'b1, 1'b1, 8'd0});
    end
    tick();
    k = 1;
    tests++;
    if ({start, dut_state} !== {1'b0, 8'd1}) begin
      fails++; $display("FAIL single_wait_busy: got %h expected %h", {start, dut_state}, {1'b0, 8'd1});
    end
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tests++;
    if (k !== 6) begin
      fails++; $display("FAIL single_done_delay: got %0d expected 6", k);
    end
    tick();
    tests++;
    if ({done, dut_state, pending, completed} !== {1'b0, 8'd0, 8'd1, 16'd0}) begin
      fails++; $display("FAIL single_wait_idle: got %h expected %h",
                        {done, dut_state, pending, completed}, {1'b0, 8'd0, 8'd1, 16'd0});
    end
    tick();
    tests++;
    if ({pending, completed, error, busy} !== {8'd0, 16'd1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL single_end: got %h expected %h",
                        {pending, completed, error, busy}, {8'd0, 16'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_burst();
    int d1, d2;
    start_q.delete();
    req = 1'b1;
    tick();
    tick();
    tick();
    req = 1'b0;
    tests++;
    if (pending !== 8'd3) begin
      fails++; $display("FAIL burst_pending_peak: got %0d expected 3", pending);
    end
    for (int k = 0; k < 60 && completed !== 16'd4; k++) tick();
    tests++;
    if ({completed, pending} !== {16'd4, 8'd0}) begin
      fails++; $display("FAIL burst_end: got %h expected %h", {completed, pending}, {16'd4, 8'd0});
    end
    tests++;
    if (start_q.size() !== 3) begin
      fails++; $display("FAIL burst_start_count: got %0d expected 3", start_q.size());
    end
    d1 = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
    d2 = (start_q.size() >= 3) ? start_q[2] - start_q[1] : -1;
    tests++;
    if (d1 !== 9 || d2 !== 9) begin
      fails++; $display("FAIL burst_spacing: got %0d,%0d expected 9,9", d1, d2);
    end
  endtask

  task automatic test_simultaneous();
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    for (int k = 0; k < 30 && done !== 1'b1; k++) tick();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL simul_done_seen: got %b expected 1", done);
    end
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    tests++;
    if ({pending, completed} !== {8'd2, 16'd5}) begin
      fails++; $display("FAIL simul_pending: got %h expected %h", {pending, completed}, {8'd2, 16'd5});
    end
    for (int k = 0; k < 60 && pending !== 8'd0; k++) tick();
    tests++;
    if ({pending, completed} !== {8'd0, 16'd7}) begin
      fails++; $display("FAIL simul_drain: got %h expected %h", {pending, completed}, {8'd0, 16'd7});
    end
  endtask

  task automatic test_stuck();
    ovr_en  = 1'b1;
    ovr_val = 8'd0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    tests++;
    if (error !== 1'b0) begin
      fails++; $display("FAIL stuck_early: got %b expected 0", error);
    end
    tick();
    tests++;
    if ({error, busy, start, done, pending} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      fails++; $display("FAIL stuck_timeout: got %h expected %h",
                        {error, busy, start, done, pending}, {1'b1, 1'b1, 1'b0, 1'b0, 8'd1});
    end
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    tick();
    tests++;
    if ({pending, completed, start, done, error} !== {8'd1, 16'd7, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL stuck_frozen: got %h expected %h",
                        {pending, completed, start, done, error}, {8'd1, 16'd7, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_illegal();
    reset  = 1'b1;
    ovr_en = 1'b0;
    tick();
    reset = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if ({error, busy, dut_state} !== {1'b0, 1'b1, 8'd1}) begin
      fails++; $display("FAIL illegal_in_work: got %h expected %h", {error, busy, dut_state}, {1'b0, 1'b1, 8'd1});
    end
    ovr_en  = 1'b1;
    ovr_val = 8'd7;
    tick();
    tests++;
    if ({error, busy, start, done} !== 4'b1100) begin
      fails++; $display("FAIL illegal_error: got %b expected 1100", {error, busy, start, done});
    end
    reset  = 1'b1;
    ovr_en = 1'b0;
    tick();
    reset = 1'b0;
    tests++;
    if ({start, done, busy, error, pending, completed} !== 28'd0) begin
      fails++; $display("FAIL illegal_reset: got %h expected 0", {start, done, busy, error, pending, completed});
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 0; k < 30 && completed !== 16'd1; k++) tick();
    tests++;
    if ({completed, pending, error} !== {16'd1, 8'd0, 1'b0}) begin
      fails++; $display("FAIL illegal_resume: got %h expected %h", {completed, pending, error}, {16'd1, 8'd0, 1'b0});
    end
  endtask

  task automatic test_saturation();
    sat_req = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    tests++;
    if (sat_pending !== 8'd254) begin
      fails++; $display("FAIL sat_254: got %0d expected 254", sat_pending);
    end
    tick();
    tests++;
    if (sat_pending !== 8'd255) begin
      fails++; $display("FAIL sat_255: got %0d expected 255", sat_pending);
    end
    for (int i = 0; i < 5; i++) tick();
    sat_req = 1'b0;
    tests++;
    if ({sat_pending, sat_completed, sat_error, sat_busy, sat_start, sat_done}
        !== {8'd255, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sat_hold: got %h expected %h",
                        {sat_pending, sat_completed, sat_error, sat_busy, sat_start, sat_done},
                        {8'd255, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_stuck();
    test_illegal();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
